cram_axi_rd_slave: RTL and testbench
====================================

Name: cram_axi_rd_slave

Overview:
- AXI4 read-only responder in front of the code RAM (cram).
- Serves instruction-fetch reads and debug or loader bursts issued by the fetch/scheduler side of fcpu.
- Drives a synchronous single-port RAM read interface with 1-cycle latency.
- A 2-entry output buffer absorbs rready backpressure without losing RAM data.

Parameters:
- ADDR_W, CRAM_ADDR_W (15): byte-address width decoded from araddr.
- DATA_W, 32: data beat width.
- ID_W, 4: AXI ID width.
- MEM_DEPTH, 8192: number of RAM words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_cram_arid  in  ID_W  read ID.
- s_cram_araddr  in  32  byte address; bits [1:0] ignored; bits [ADDR_W-1:2] form the word address.
- s_cram_arlen  in  8  beats minus 1.
- s_cram_arsize  in  3  only 3'h2 supported.
- s_cram_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP (treated as INCR).
- s_cram_arvalid  in  1.
- s_cram_arready  out  1.
- s_cram_rid  out  ID_W.
- s_cram_rdata  out  DATA_W.
- s_cram_rresp  out  2.
- s_cram_rlast  out  1.
- s_cram_rvalid  out  1.
- s_cram_rready  in  1.
- mem_en  out  1  RAM read enable.
- mem_addr  out  ADDR_W-2  RAM word address.
- mem_rdata  in  DATA_W  valid the cycle after mem_en.

Behaviour:
- Reset (async assert, sync release):
  - arready, rvalid, rlast, mem_en = 0.
  - rid, rdata, rresp, mem_addr = 0.
  - FSM = IDLE; buffer emptied; in-flight cleared.
  - A reset during a burst aborts it silently; no further beats are returned.
- FSM states: IDLE, BURST.
- IDLE:
  - arready = 1 (registered) only when the buffer is empty and no RAM read is in flight.
  - On arvalid&&arready: latch id, word address, beats_left=arlen, burst type, and size_err=(arsize!=2). Next state BURST; arready drops the following cycle.
- BURST:
  - Issue condition: occupancy + inflight < 2. When it holds, assert mem_en with mem_addr = current word address.
  - INCR/WRAP: the word address increments by 1 per issue, modulo 2^(ADDR_W-2). No 4KB-boundary check.
  - FIXED: the address is held.
  - Each issue tags the returning entry with last=(beats_left==0), then decrements beats_left.
  - The issue with beats_left==0 returns the FSM to IDLE. The next AR is accepted only after that last beat has completed its R handshake.
- Output buffer:
  - rvalid = buffer not empty.
  - The head drives rid/rdata/rresp/rlast.
  - Pop on rvalid&&rready.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Outputs are held stable while rvalid&&!rready (AXI rule).
- Latency: AR handshake in cycle N, mem_en in N+1, first rvalid in N+2. With rready=1 held, one beat per cycle; a burst of L beats ends with rlast at N+1+L.
- size_err: every beat returns rresp=2'b10 (SLVERR) and rdata=0. mem_en is suppressed. All arlen+1 beats are still returned.
- Normal beats return rresp=2'b00 (OKAY).
- rlast asserts on exactly one beat per burst: the final one.

Optional Feature:
- Macro: CRAM_RD_RANGE_CHECK_EN.
- Defined: a beat whose word address is >= MEM_DEPTH returns SLVERR with rdata=0, and mem_en is suppressed for that beat. Later in-range beats of the same burst return OKAY.
- Undefined: no range check. mem_addr is truncated to clog2(MEM_DEPTH) bits and all beats return OKAY unless size_err.

Decomposition:
- fcpu_pkg additions:
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - typedef enum axi_burst_t {FIXED, INCR, WRAP}.
  - typedef enum rd_state_t {RD_IDLE, RD_BURST}.
  - packed struct cram_rbeat_t {id, data, resp, last}.
- Sub-module: cram_rd_skid_fifo, a 2-entry FIFO of cram_rbeat_t exposing count, push, pop, head, async rst.

Test Plan:
1. Single beat: araddr=0x0010, arlen=0, rready=1 -> mem_addr=4 at N+1; rvalid with rdata=RAM[4], rlast=1, rresp=OKAY at N+2; arready=1 again at N+3.
2. INCR burst: araddr=0x0100, arlen=7, rready=1 -> 8 consecutive beats RAM[64..71]; rlast only on beat 8; rid echoes arid=4'h5.
3. Backpressure: arlen=3, rready toggles 1,0,0,1,1,0,1 -> no beat lost or duplicated; rdata stable while stalled; occupancy never exceeds 2.
4. Address wrap and FIXED: araddr=0x7FFC, arlen=1, INCR -> RAM[8191] then RAM[0]. FIXED, arlen=2 -> RAM[k] returned three times.
5. Error and reset: arsize=3'h1, arlen=2 -> 3 beats, SLVERR, rdata=0, no mem_en. Separately, rst asserted mid-burst -> rvalid=0 and arready=0 immediately; arready=1 one cycle after release.

Source files
------------

// File: rtl/cram_axi_rd_slave_pkg.sv
// Shared types for the code-RAM AXI read responder: response codes, burst and
// FSM encodings, and the beat record carried through the output buffer.
package cram_axi_rd_slave_pkg;

  localparam int CRAM_ID_W   = 4;
  localparam int CRAM_DATA_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_t;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_t;

  typedef struct packed {
    logic [CRAM_ID_W-1:0]   id;
    logic [CRAM_DATA_W-1:0] data;
    logic [1:0]             resp;
    logic                   last;
  } cram_rbeat_t;

endpackage

// File: rtl/cram_rd_skid_fifo.sv
// Two-entry beat buffer that holds returned RAM data while the master stalls rready.
// The caller guarantees no push when full and no pop when empty.
module cram_rd_skid_fifo
  import cram_axi_rd_slave_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  cram_rbeat_t din,
  output cram_rbeat_t head,
  output logic [1:0]  count
);

  cram_rbeat_t slots [2];
  logic        wr_ptr;
  logic        rd_ptr;

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/cram_axi_rd_slave.sv
// AXI4 read-only responder in front of the 1-cycle-latency code RAM.
// Optional macro CRAM_RD_RANGE_CHECK_EN: beats addressing >= MEM_DEPTH return SLVERR without a RAM read.
module cram_axi_rd_slave
  import cram_axi_rd_slave_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = CRAM_DATA_W,
  parameter int ID_W      = CRAM_ID_W,
  parameter int MEM_DEPTH = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_cram_arid,
  input  logic [31:0]       s_cram_araddr,
  input  logic [7:0]        s_cram_arlen,
  input  logic [2:0]        s_cram_arsize,
  input  logic [1:0]        s_cram_arburst,
  input  logic              s_cram_arvalid,
  output logic              s_cram_arready,
  output logic [ID_W-1:0]   s_cram_rid,
  output logic [DATA_W-1:0] s_cram_rdata,
  output logic [1:0]        s_cram_rresp,
  output logic              s_cram_rlast,
  output logic              s_cram_rvalid,
  input  logic              s_cram_rready,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WA_W = ADDR_W - 2;

  rd_state_t   state, next_state;
  logic        arready_q;
  logic [ID_W-1:0] id_q;
  logic [WA_W-1:0] addr_q;
  logic [7:0]  beats_left;
  logic        fixed_q;
  logic        size_err_q;
  logic        inflight;
  logic [ID_W-1:0] infl_id;
  logic        infl_err;
  logic        infl_last;
  logic        accept;
  logic        issue;
  logic        beat_err;
  logic        range_err;
  logic [1:0]  fifo_count;
  logic [1:0]  count_next;
  logic        fifo_push;
  logic        fifo_pop;
  logic        beat_valid;
  logic        next_arready;
  cram_rbeat_t fifo_head;
  cram_rbeat_t infl_beat;
  cram_rbeat_t head;
  logic        unused_araddr;

  assign unused_araddr = ^{s_cram_araddr[31:ADDR_W], s_cram_araddr[1:0]};

`ifdef CRAM_RD_RANGE_CHECK_EN
  assign range_err = (32'(addr_q) >= 32'(MEM_DEPTH));
  assign mem_addr  = addr_q;
`else
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  assign range_err = 1'b0;
  if (MEM_AW < WA_W) begin : g_trunc
    assign mem_addr = {{(WA_W-MEM_AW){1'b0}}, addr_q[MEM_AW-1:0]};
  end else begin : g_full
    assign mem_addr = addr_q;
  end
`endif

  assign beat_err = size_err_q | range_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    mem_en     = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (s_cram_arvalid && arready_q) begin
          accept     = 1'b1;
          next_state = RD_BURST;
        end
      end
      RD_BURST: begin
        if (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2) begin
          issue  = 1'b1;
          mem_en = ~beat_err;
          if (beats_left == 8'd0) next_state = RD_IDLE;
        end
      end
      default: next_state = RD_IDLE;
    endcase
  end

  // The beat whose RAM data arrives this cycle is presented directly when the
  // buffer is empty; it only enters the buffer if the master does not take it.
  assign beat_valid = (fifo_count != 2'd0) || inflight;
  assign fifo_pop   = (fifo_count != 2'd0) && s_cram_rready;
  assign fifo_push  = inflight && !((fifo_count == 2'd0) && s_cram_rready);

  always_comb begin
    count_next   = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    next_arready = (next_state == RD_IDLE) && (count_next == 2'd0) && !issue;
  end

  always_comb begin
    infl_beat      = '0;
    infl_beat.id   = infl_id;
    infl_beat.data = infl_err ? '0 : mem_rdata;
    infl_beat.resp = infl_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    infl_beat.last = infl_last;
    head = '0;
    if (fifo_count != 2'd0) head = fifo_head;
    else if (inflight)      head = infl_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      beats_left <= '0;
      fixed_q    <= 1'b0;
      size_err_q <= 1'b0;
      inflight   <= 1'b0;
      infl_id    <= '0;
      infl_err   <= 1'b0;
      infl_last  <= 1'b0;
    end else begin
      arready_q <= next_arready;
      inflight  <= issue;
      if (accept) begin
        id_q       <= s_cram_arid;
        addr_q     <= s_cram_araddr[ADDR_W-1:2];
        beats_left <= s_cram_arlen;
        fixed_q    <= (axi_burst_t'(s_cram_arburst) == FIXED);
        size_err_q <= (s_cram_arsize != 3'h2);
      end
      if (issue) begin
        if (!fixed_q) addr_q <= addr_q + WA_W'(1);
        beats_left <= beats_left - 8'd1;
        infl_id    <= id_q;
        infl_err   <= beat_err;
        infl_last  <= (beats_left == 8'd0);
      end
    end
  end

  cram_rd_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (infl_beat),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign s_cram_arready = arready_q;
  assign s_cram_rvalid  = beat_valid;
  assign s_cram_rid     = head.id;
  assign s_cram_rdata   = head.data;
  assign s_cram_rresp   = head.resp;
  assign s_cram_rlast   = head.last;

endmodule

// File: tb/tb_cram_axi_rd_slave.sv
// Self-checking bench for cram_axi_rd_slave: directed scenarios plus randomized
// bursts compared against a queue-based model of the expected beat stream.
`timescale 1ns/1ps
module tb_cram_axi_rd_slave;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        mem_en;
  logic [12:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          cyc;
  } beat_t;

  logic [31:0] ram [DEPTH];
  bit bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

  cram_axi_rd_slave #(
    .ADDR_W    (15),
    .DATA_W    (32),
    .ID_W      (4),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_cram_arid    (arid),
    .s_cram_araddr  (araddr),
    .s_cram_arlen   (arlen),
    .s_cram_arsize  (arsize),
    .s_cram_arburst (arburst),
    .s_cram_arvalid (arvalid),
    .s_cram_arready (arready),
    .s_cram_rid     (rid),
    .s_cram_rdata   (rdata),
    .s_cram_rresp   (rresp),
    .s_cram_rlast   (rlast),
    .s_cram_rvalid  (rvalid),
    .s_cram_rready  (rready),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata)
  );

  // Reference: beat i reads word (start+i) mod DEPTH, or start for FIXED.
  task automatic model(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output beat_t exp[$]);
    int word;
    int a;
    beat_t b;
    exp.delete();
    word = int'(addr[14:2]);
    for (int i = 0; i <= int'(len); i++) begin
      a      = (burst == 2'd0) ? word : (word + i) % DEPTH;
      b.id   = id;
      b.resp = (size != 3'd2) ? 2'b10 : 2'b00;
      b.data = (size != 3'd2) ? 32'h0 : ram[a];
      b.last = (i == int'(len));
      b.cyc  = 0;
      exp.push_back(b);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit ok);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (arready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
  endtask

  // Collects n R beats; cycle 0 is the cycle right after the AR handshake.
  task automatic collect(input int n, input int mode, output beat_t got[$], output int unstable,
                         output int en_cnt, output int en_cyc, output logic [12:0] en_addr);
    beat_t b;
    logic [39:0] cur;
    logic [39:0] snap;
    logic prev_stall;
    int c;
    got.delete();
    unstable = 0; en_cnt = 0; en_cyc = -1; en_addr = '0;
    prev_stall = 1'b0; snap = '0; c = 0;
    while (got.size() < n && c < 3000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = bp_pat[c % 7];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      cur = {rvalid, rid, rdata, rresp, rlast};
      if (prev_stall && cur !== snap) unstable++;
      prev_stall = rvalid && !rready;
      snap = cur;
      if (mem_en) begin
        if (en_cnt == 0) begin en_cyc = c; en_addr = mem_addr; end
        en_cnt++;
      end
      if (rvalid && rready) begin
        b.id = rid; b.data = rdata; b.resp = rresp; b.last = rlast; b.cyc = c;
        got.push_back(b);
      end
      @(posedge clk); #1;
      c++;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({arready, rvalid, rlast, mem_en, rid, rdata, rresp, mem_addr} !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h required 0",
        {arready, rvalid, rlast, mem_en, rid, rdata, rresp, mem_addr}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL reset_arready: got %b required 1", arready); end
  endtask

  task automatic test_single();
    beat_t got[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    send_ar(4'h3, 32'h0000_0010, 8'd0, 3'd2, 2'd1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_ar: got no handshake required handshake"); end
    collect(1, 0, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (en_cyc !== 0 || en_addr !== 13'd4)
      begin failures++; $display("FAIL single_mem: got cyc %0d addr %0d required cyc 0 addr 4", en_cyc, en_addr); end
    checks++;
    if (got.size() != 1) begin failures++; $display("FAIL single_count: got %0d beats required 1", got.size()); end
    else if (got[0].cyc != 1 || got[0].data !== ram[4] || got[0].resp !== 2'b00 || got[0].last !== 1'b1 || got[0].id !== 4'h3)
      begin failures++; $display("FAIL single_beat: got cyc %0d data %h resp %b last %b id %h required cyc 1 data %h resp 00 last 1 id 3",
        got[0].cyc, got[0].data, got[0].resp, got[0].last, got[0].id, ram[4]); end
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0)
      begin failures++; $display("FAIL single_rearm: got arready %b rvalid %b required 1 0", arready, rvalid); end
  endtask

  task automatic test_incr();
    beat_t got[$]; beat_t exp[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    model(4'h5, 32'h0000_0100, 8'd7, 3'd2, 2'd1, exp);
    send_ar(4'h5, 32'h0000_0100, 8'd7, 3'd2, 2'd1, ok);
    collect(8, 0, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (!ok || got.size() != 8) begin failures++; $display("FAIL incr_count: got %0d beats required 8", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (i >= got.size()) begin failures++; $display("FAIL incr_beat%0d: got nothing required data %h", i, exp[i].data); end
      else if ({got[i].id, got[i].data, got[i].resp, got[i].last} !== {exp[i].id, exp[i].data, exp[i].resp, exp[i].last} || got[i].cyc != i + 1)
        begin failures++; $display("FAIL incr_beat%0d: got id %h data %h last %b cyc %0d required id %h data %h last %b cyc %0d",
          i, got[i].id, got[i].data, got[i].last, got[i].cyc, exp[i].id, exp[i].data, exp[i].last, i + 1); end
    end
  endtask

  task automatic test_backpressure();
    beat_t got[$]; beat_t exp[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    model(4'hA, 32'h0000_0A04, 8'd3, 3'd2, 2'd1, exp);
    send_ar(4'hA, 32'h0000_0A04, 8'd3, 3'd2, 2'd1, ok);
    collect(4, 1, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (!ok || got.size() != 4) begin failures++; $display("FAIL bp_count: got %0d beats required 4", got.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if ({got[i].id, got[i].data, got[i].resp, got[i].last} !== {exp[i].id, exp[i].data, exp[i].resp, exp[i].last})
        begin failures++; $display("FAIL bp_beat%0d: got data %h last %b required data %h last %b",
          i, got[i].data, got[i].last, exp[i].data, exp[i].last); end
    end
    checks++;
    if (unst != 0) begin failures++; $display("FAIL bp_stable: got %0d changes while stalled required 0", unst); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL bp_extra: got rvalid %b required 0", rvalid); end
  endtask

  task automatic test_wrap_fixed();
    beat_t got[$]; beat_t exp[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    logic [31:0] kaddr;
    model(4'h1, 32'h0000_7FFC, 8'd1, 3'd2, 2'd1, exp);
    send_ar(4'h1, 32'h0000_7FFC, 8'd1, 3'd2, 2'd1, ok);
    collect(2, 0, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (!ok || got.size() != 2 || got[0].data !== ram[8191] || got[1].data !== ram[0] || got[1].last !== 1'b1)
      begin failures++; $display("FAIL wrap_beats: got %0d beats required RAM[8191]=%h then RAM[0]=%h", got.size(), ram[8191], ram[0]); end
    kaddr = {17'h0, 13'($urandom_range(0, DEPTH - 1)), 2'b00};
    model(4'h2, kaddr, 8'd2, 3'd2, 2'd0, exp);
    send_ar(4'h2, kaddr, 8'd2, 3'd2, 2'd0, ok);
    collect(3, 2, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (!ok || got.size() != 3) begin failures++; $display("FAIL fixed_count: got %0d beats required 3", got.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if ({got[i].data, got[i].resp, got[i].last} !== {exp[i].data, exp[i].resp, exp[i].last})
        begin failures++; $display("FAIL fixed_beat%0d: got data %h last %b required data %h last %b",
          i, got[i].data, got[i].last, exp[i].data, exp[i].last); end
    end
  endtask

  task automatic test_size_err();
    beat_t got[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    send_ar(4'h7, 32'h0000_0040, 8'd2, 3'd1, 2'd1, ok);
    collect(3, 0, got, unst, en_cnt, en_cyc, en_addr);
    checks++;
    if (!ok || got.size() != 3) begin failures++; $display("FAIL serr_count: got %0d beats required 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i].resp !== 2'b10 || got[i].data !== 32'h0 || got[i].last !== (i == 2))
        begin failures++; $display("FAIL serr_beat%0d: got resp %b data %h last %b required resp 10 data 0 last %0d",
          i, got[i].resp, got[i].data, got[i].last, (i == 2)); end
    end
    checks++;
    if (en_cnt != 0) begin failures++; $display("FAIL serr_mem_en: got %0d reads required 0", en_cnt); end
  endtask

  task automatic test_random();
    beat_t got[$]; beat_t exp[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok;
    logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    for (int t = 0; t < 10; t++) begin
      id    = 4'($urandom);
      addr  = $urandom;
      len   = 8'($urandom_range(0, 15));
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'd2;
      burst = 2'($urandom_range(0, 2));
      model(id, addr, len, size, burst, exp);
      send_ar(id, addr, len, size, burst, ok);
      collect(exp.size(), 2, got, unst, en_cnt, en_cyc, en_addr);
      checks++;
      if (!ok || got.size() != exp.size())
        begin failures++; $display("FAIL rand%0d_count: got %0d beats required %0d", t, got.size(), exp.size()); end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
        checks++;
        if ({got[i].id, got[i].data, got[i].resp, got[i].last} !== {exp[i].id, exp[i].data, exp[i].resp, exp[i].last})
          begin failures++; $display("FAIL rand%0d_beat%0d: got id %h data %h resp %b last %b required id %h data %h resp %b last %b",
            t, i, got[i].id, got[i].data, got[i].resp, got[i].last, exp[i].id, exp[i].data, exp[i].resp, exp[i].last); end
      end
      checks++;
      if (unst != 0 || en_cnt != ((size != 3'd2) ? 0 : int'(len) + 1))
        begin failures++; $display("FAIL rand%0d_misc: got unstable %0d reads %0d required 0 and %0d",
          t, unst, en_cnt, (size != 3'd2) ? 0 : int'(len) + 1); end
    end
  endtask

  task automatic test_reset_mid();
    beat_t got[$]; int unst, en_cnt, en_cyc; logic [12:0] en_addr; bit ok; int seen;
    send_ar(4'h9, 32'h0000_0200, 8'd15, 3'd2, 2'd1, ok);
    collect(3, 0, got, unst, en_cnt, en_cyc, en_addr);
    rst = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || mem_en !== 1'b0)
      begin failures++; $display("FAIL rstmid_now: got rvalid %b arready %b mem_en %b required 0 0 0", rvalid, arready, mem_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (arready !== 1'b1) begin failures++; $display("FAIL rstmid_arready: got %b required 1", arready); end
    seen = 0;
    rready = 1'b1;
    repeat (6) begin
      if (rvalid || mem_en) seen++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rstmid_abort: got %0d active cycles required 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    rready = 1'b0;
    test_reset();
    test_single();
    test_incr();
    test_backpressure();
    test_wrap_fixed();
    test_size_err();
    test_random();
    test_reset_mid();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
